// File: rtl/cordic_engine_if.sv
`default_nettype none
// ============================================================================
//  Module   : cordic_engine_if
//  Brief    : Request/result bundle between a CORDIC client and cordic_engine.
//  Revision : 1.0  initial release
// ============================================================================
interface cordic_engine_if #(
    parameter int WIDTH = 32
);
    logic                    start;
    logic                    mode;
    logic        [WIDTH-1:0] angle;
    logic signed [WIDTH-1:0] in_x;
    logic signed [WIDTH-1:0] in_y;
    logic                    busy;
    logic                    done;
    logic signed [WIDTH-1:0] out_x;
    logic signed [WIDTH-1:0] out_y;
    logic        [WIDTH-1:0] out_z;

    modport master (
        output start, mode, angle, in_x, in_y,
        input  busy, done, out_x, out_y, out_z
    );

    modport slave (
        input  start, mode, angle, in_x, in_y,
        output busy, done, out_x, out_y, out_z
    );
endinterface
`default_nettype wire

// File: rtl/cordic_engine.sv
`default_nettype none
// ============================================================================
//  Module   : cordic_engine
//  Brief    : Iterative full-circle CORDIC, rotation and vectoring modes.
//  Revision : 1.0  initial release
// ============================================================================
module cordic_engine #(
    parameter int WIDTH = 32,
    parameter int ITERS = 24
) (
    input  logic            clk,
    input  logic            reset,
    cordic_engine_if.slave  bus
);
    typedef logic        [WIDTH-1:0] word_t;
    typedef logic signed [WIDTH+1:0] xy_t;

    localparam real   c_pi      = 3.14159265358979323846;
    localparam int    c_cnt_w   = $clog2(ITERS);
    localparam int    c_tab_n   = 2 ** c_cnt_w;
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(ITERS - 1);
    localparam word_t c_half    = {1'b1, {(WIDTH-1){1'b0}}};
    localparam word_t c_quarter = {2'b01, {(WIDTH-2){1'b0}}};

    if (WIDTH < 8 || ITERS < 4 || ITERS > WIDTH - 2) begin : g_param_check
        $error("cordic_engine: WIDTH must be >= 8 and ITERS in 4..WIDTH-2");
    end

    function automatic word_t f_atan(input int idx);
        real p;
        real scale;
        p     = 1.0;
        scale = 1.0;
        for (int k = 0; k < idx; k++)   p     = p / 2.0;
        for (int k = 0; k < WIDTH; k++) scale = scale * 2.0;
        return word_t'($floor($atan(p) * scale / (2.0 * c_pi) + 0.5));
    endfunction

    // Rotation seed pre-divided by the CORDIC gain so the result lands on S.
    function automatic xy_t f_x0();
        real k;
        real p;
        real s;
        k = 1.0;
        p = 1.0;
        s = 1.0;
        for (int i = 0; i < ITERS; i++) begin
            k = k * $sqrt(1.0 + p * p);
            p = p / 2.0;
        end
        for (int i = 0; i < WIDTH - 2; i++) s = s * 2.0;
        return xy_t'($floor(s / k + 0.5));
    endfunction

    localparam xy_t c_x0 = f_x0();

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_ITER = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t                  r_state;
    state_t                  w_next;
    logic                    r_mode;
    word_t                   r_angle;
    logic signed [WIDTH-1:0] r_in_x;
    logic signed [WIDTH-1:0] r_in_y;
    xy_t                     r_x;
    xy_t                     r_y;
    word_t                   r_z;
    logic    [c_cnt_w-1:0]   r_iter;
    logic                    r_busy;
    logic                    r_done;
    logic signed [WIDTH-1:0] r_out_x;
    logic signed [WIDTH-1:0] r_out_y;
    word_t                   r_out_z;

    word_t w_atan_tab [c_tab_n];
    for (genvar gi = 0; gi < c_tab_n; gi++) begin : g_atan
        assign w_atan_tab[gi] = f_atan(gi);
    end

    xy_t   w_x_load;
    xy_t   w_y_load;
    word_t w_z_load;
    xy_t   w_x_step;
    xy_t   w_y_step;
    word_t w_z_step;
    xy_t   w_sx;
    xy_t   w_sy;
    logic  w_neg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (bus.start) w_next = S_LOAD;
            S_LOAD:  w_next = S_ITER;
            S_ITER:  if (r_iter == c_last) w_next = S_DONE;
            default: w_next = S_IDLE;
        endcase
    end

    // Quadrant pre-rotation leaves a residual in [-pi/2, pi/2) for the micro-rotations.
    always_comb begin
        w_x_load = c_x0;
        w_y_load = '0;
        w_z_load = r_angle;
        if (r_mode) begin
            if (r_in_x[WIDTH-1]) begin
                w_x_load = -xy_t'(r_in_x);
                w_y_load = -xy_t'(r_in_y);
                w_z_load = c_half;
            end else begin
                w_x_load = xy_t'(r_in_x);
                w_y_load = xy_t'(r_in_y);
                w_z_load = '0;
            end
        end else begin
            case (r_angle[WIDTH-1 -: 2])
                2'b01: begin
                    w_x_load = '0;
                    w_y_load = c_x0;
                    w_z_load = r_angle - c_quarter;
                end
                2'b10: begin
                    w_x_load = -c_x0;
                    w_z_load = r_angle - c_half;
                end
                default: ;
            endcase
        end
    end

    // w_neg selects d = -1: negative residual angle, or non-negative y when vectoring.
    always_comb begin
        w_sx  = r_x >>> r_iter;
        w_sy  = r_y >>> r_iter;
        w_neg = r_mode ? ~r_y[WIDTH+1] : r_z[WIDTH-1];
        if (w_neg) begin
            w_x_step = r_x + w_sy;
            w_y_step = r_y - w_sx;
            w_z_step = r_z + w_atan_tab[r_iter];
        end else begin
            w_x_step = r_x - w_sy;
            w_y_step = r_y + w_sx;
            w_z_step = r_z - w_atan_tab[r_iter];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_mode  <= 1'b0;
            r_angle <= '0;
            r_in_x  <= '0;
            r_in_y  <= '0;
            r_x     <= '0;
            r_y     <= '0;
            r_z     <= '0;
            r_iter  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_out_x <= '0;
            r_out_y <= '0;
            r_out_z <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (bus.start) begin
                    r_mode  <= bus.mode;
                    r_angle <= bus.angle;
                    r_in_x  <= bus.in_x;
                    r_in_y  <= bus.in_y;
                    r_busy  <= 1'b1;
                    r_done  <= 1'b0;
                end
                S_LOAD: begin
                    r_x    <= w_x_load;
                    r_y    <= w_y_load;
                    r_z    <= w_z_load;
                    r_iter <= '0;
                end
                S_ITER: begin
                    r_x    <= w_x_step;
                    r_y    <= w_y_step;
                    r_z    <= w_z_step;
                    r_iter <= r_iter + 1'b1;
                end
                default: begin
                    r_out_x <= r_x[WIDTH-1:0];
                    r_out_y <= r_y[WIDTH-1:0];
                    r_out_z <= r_z;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                end
            endcase
        end
    end

    assign bus.busy  = r_busy;
    assign bus.done  = r_done;
    assign bus.out_x = r_out_x;
    assign bus.out_y = r_out_y;
    assign bus.out_z = r_out_z;
endmodule
`default_nettype wire

// File: tb/tb_cordic_engine.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cordic_engine
//  Brief    : Scoreboard bench for cordic_engine at 32/24 and 16/14 geometry.
//  Revision : 1.0  initial release
// ============================================================================
module tb_cordic_engine;
    localparam int T32  = 152;   // 2^(32-1-24) + 24
    localparam int TZ32 = 280;   // 2^(32-24) + 24
    localparam int T16  = 16;    // 2^(16-1-14) + 14
    localparam int TZ16 = 18;    // 2^(16-14) + 14

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   acc;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    cordic_engine_if #(.WIDTH(32)) bus32();
    cordic_engine_if #(.WIDTH(16)) bus16();

    cordic_engine #(.WIDTH(32), .ITERS(24)) dut32 (.clk(clk), .reset(reset), .bus(bus32));
    cordic_engine #(.WIDTH(16), .ITERS(14)) dut16 (.clk(clk), .reset(reset), .bus(bus16));

    typedef struct {
        int    x;
        int    y;
        int    z;
        bit    chk_z;
        int    tol;
        int    tolz;
        int    acc;
        int    lat;
        string name;
    } exp_t;

    exp_t q32[$];
    exp_t q16[$];

    function automatic int wrapd(input int d, input int w);
        int s;
        s = d <<< (32 - w);
        return s >>> (32 - w);
    endfunction

    task automatic check_near(input string nm, input int act, input int exp, input int tol, input int w);
        int d;
        d = wrapd(act - exp, w);
        checks++;
        if (d > tol || d < -tol) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d +/- %0d", nm, act, exp, tol);
        end
    endtask

    task automatic check_eq(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic mon_compare(input exp_t e, input int ax, input int ay, input int az, input int w);
        check_near({e.name, "_x"}, ax, e.x, e.tol, w);
        check_near({e.name, "_y"}, ay, e.y, e.tol, w);
        if (e.chk_z) check_near({e.name, "_z"}, az, e.z, e.tolz, w);
        check_eq({e.name, "_latency"}, cyc - e.acc, e.lat);
    endtask

    logic prev32 = 1'b0;
    logic prev16 = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        if (reset && bus32.done && !prev32) begin
            if (q32.size() == 0) check_eq("unexpected_done32", 1, 0);
            else begin
                e = q32.pop_front();
                mon_compare(e, int'(bus32.out_x), int'(bus32.out_y), int'(bus32.out_z), 32);
            end
        end
        if (reset && bus16.done && !prev16) begin
            if (q16.size() == 0) check_eq("unexpected_done16", 1, 0);
            else begin
                e = q16.pop_front();
                mon_compare(e, int'(bus16.out_x), int'(bus16.out_y), int'(bus16.out_z), 16);
            end
        end
        prev32 = bus32.done;
        prev16 = bus16.done;
    end

    task automatic issue32(input string nm, input bit md, input logic [31:0] ang,
                           input int ix, input int iy, input int ex, input int ey,
                           input int ez, input bit cz, input bit push, input bit hold);
        @(negedge clk);
        bus32.start = 1'b1;
        bus32.mode  = md;
        bus32.angle = ang;
        bus32.in_x  = ix;
        bus32.in_y  = iy;
        @(posedge clk);
        #1;
        acc = cyc;
        if (push) q32.push_back('{ex, ey, ez, cz, T32, TZ32, acc, 26, nm});
        if (!hold) begin
            @(negedge clk);
            bus32.start = 1'b0;
        end
    endtask

    task automatic issue16(input string nm, input logic [15:0] ang, input int ex, input int ey);
        @(negedge clk);
        bus16.start = 1'b1;
        bus16.mode  = 1'b0;
        bus16.angle = ang;
        @(posedge clk);
        #1;
        q16.push_back('{ex, ey, 0, 1'b1, T16, TZ16, cyc, 16, nm});
        @(negedge clk);
        bus16.start = 1'b0;
    endtask

    task automatic wait_idle32(input string nm);
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 100 && !ok; n++) begin
            @(negedge clk);
            ok = !bus32.busy && bus32.done;
        end
        check_eq({nm, "_idle_done"}, int'(ok), 1);
    endtask

    task automatic wait_idle16(input string nm);
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 100 && !ok; n++) begin
            @(negedge clk);
            ok = !bus16.busy && bus16.done;
        end
        check_eq({nm, "_idle_done"}, int'(ok), 1);
    endtask

    initial begin
        bus32.start = 1'b0; bus32.mode = 1'b0; bus32.angle = '0; bus32.in_x = '0; bus32.in_y = '0;
        bus16.start = 1'b0; bus16.mode = 1'b0; bus16.angle = '0; bus16.in_x = '0; bus16.in_y = '0;
        #12;
        check_eq("rst_busy", int'(bus32.busy), 0);
        check_eq("rst_done", int'(bus32.done), 0);
        check_eq("rst_out_x", int'(bus32.out_x), 0);
        check_eq("rst_out_y", int'(bus32.out_y), 0);
        check_eq("rst_out_z", int'(bus32.out_z), 0);
        check_eq("rst16_done", int'(bus16.done), 0);
        @(negedge clk);
        reset = 1'b1;

        issue32("rot0", 1'b0, 32'h0000_0000, 0, 0, 1073741824, 0, 0, 1'b1, 1'b1, 1'b0);
        wait_idle32("rot0");
        issue32("rot45", 1'b0, 32'h2000_0000, 0, 0, 759250125, 759250125, 0, 1'b1, 1'b1, 1'b0);
        wait_idle32("rot45");
        issue32("rot180", 1'b0, 32'h8000_0000, 0, 0, -1073741824, 0, 0, 1'b1, 1'b1, 1'b0);
        wait_idle32("rot180");
        issue32("rot270", 1'b0, 32'hC000_0000, 0, 0, 0, -1073741824, 0, 1'b1, 1'b1, 1'b0);
        wait_idle32("rot270");
        issue32("vec", 1'b1, 32'h0, -3000000, 4000000, 8233801, 0, 1513616846, 1'b1, 1'b1, 1'b0);
        wait_idle32("vec");

        // A pulse on start mid-operation must neither delay nor queue anything.
        issue32("extra", 1'b0, 32'h2000_0000, 0, 0, 759250125, 759250125, 0, 1'b1, 1'b1, 1'b0);
        repeat (4) @(negedge clk);
        bus32.start = 1'b1;
        @(negedge clk);
        bus32.start = 1'b0;
        wait_idle32("extra");
        repeat (5) @(negedge clk);
        check_eq("extra_no_requeue_busy", int'(bus32.busy), 0);

        // Start held high: second accept lands on the edge after done rises.
        issue32("b2b_a", 1'b0, 32'h0000_0000, 0, 0, 1073741824, 0, 0, 1'b1, 1'b1, 1'b1);
        q32.push_back('{1073741824, 0, 0, 1'b1, T32, TZ32, acc + 27, 26, "b2b_b"});
        repeat (27) @(posedge clk);
        #1;
        check_eq("b2b_done_falls", int'(bus32.done), 0);
        check_eq("b2b_busy_again", int'(bus32.busy), 1);
        @(negedge clk);
        bus32.start = 1'b0;
        wait_idle32("b2b_b");

        issue32("rot180b", 1'b0, 32'h8000_0000, 0, 0, -1073741824, 0, 0, 1'b1, 1'b1, 1'b0);
        wait_idle32("rot180b");

        // Asynchronous reset in the middle of the iterations (i = 10).
        issue32("abort", 1'b0, 32'h2000_0000, 0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
        repeat (11) @(posedge clk);
        #1;
        check_eq("abort_busy_before", int'(bus32.busy), 1);
        #1;
        reset = 1'b0;
        #1;
        check_eq("abort_busy", int'(bus32.busy), 0);
        check_eq("abort_done", int'(bus32.done), 0);
        check_eq("abort_out_x", int'(bus32.out_x), 0);
        check_eq("abort_out_y", int'(bus32.out_y), 0);
        check_eq("abort_out_z", int'(bus32.out_z), 0);
        @(negedge clk);
        reset = 1'b1;
        issue32("rot90", 1'b0, 32'h4000_0000, 0, 0, 0, 1073741824, 0, 1'b1, 1'b1, 1'b0);
        wait_idle32("rot90");

        issue16("w16_rot45", 16'h2000, 11585, 11585);
        wait_idle16("w16_rot45");
        issue16("w16_rot0", 16'h0000, 16384, 0);
        wait_idle16("w16_rot0");

        repeat (3) @(negedge clk);
        check_eq("q32_empty", q32.size(), 0);
        check_eq("q16_empty", q16.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
